// File: rtl/imm_extend_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_extend_pipe_if
// Handshake and data bundle for the decode-stage immediate extender.
//   flush          : synchronous pipeline flush (branch taken / exception)
//   in_valid       : upstream holds a valid immediate field
//   in_ready       : extender can accept this cycle
//   imm_field      : raw immediate bits from the instruction word
//   imm_src        : extension mode (00/01 zero, 10 sign, 11 sign then <<2)
//   is_prefix      : current beat is an immediate-prefix instruction
//   out_valid      : ext_imm is valid
//   out_ready      : downstream accepts
//   ext_imm        : extended immediate
//   prefix_pending : a prefix is held, waiting for its consumer
// Modports: master = decode logic / pipeline register side, slave = extender.
// ----------------------------------------------------------------------------
interface imm_extend_pipe_if #(
  parameter int IMM_W = 24,
  parameter int XLEN  = 64
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm_field;
  logic [1:0]        imm_src;
  logic              is_prefix;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   ext_imm;
  logic              prefix_pending;

  modport master (
    output flush, in_valid, imm_field, imm_src, is_prefix, out_ready,
    input  in_ready, out_valid, ext_imm, prefix_pending
  );

  modport slave (
    input  flush, in_valid, imm_field, imm_src, is_prefix, out_ready,
    output in_ready, out_valid, ext_imm, prefix_pending
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// ----------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate extender for the decode stage. Extends the raw
// immediate field to XLEN bits according to imm_src and registers it behind
// a single valid/ready output stage. A prefix beat stores its field as the
// upper immediate bits for the next non-prefix beat, allowing immediates
// wider than IMM_W.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_extend_pipe_if.slave (handshake, flush, data, prefix status)
// ----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IMM_W = 24,
  parameter int XLEN  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  imm_extend_pipe_if.slave    bus
);

  localparam int UPPER_W = XLEN - IMM_W;

  typedef enum logic [0:0] {
    NO_PREFIX   = 1'b0,
    PREFIX_HELD = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IMM_W-1:0]  prefix_r;
  logic [IMM_W-1:0]  prefix_nxt_s;
  logic              out_valid_r;
  logic              out_valid_nxt_s;
  logic [XLEN-1:0]   ext_imm_r;
  logic [XLEN-1:0]   ext_imm_nxt_s;
  logic              prefix_pending_r;
  logic              in_ready_s;
  logic              accept_s;

  // Builds the extended immediate. Modes 1x sign-extend (from the prefix when
  // one is used, otherwise from the field); mode 11 shifts the whole combined
  // value left by 2 and drops the two bits that fall off the top.
  function automatic logic [XLEN-1:0] extend_imm(
    input logic [IMM_W-1:0] pfx,
    input logic             use_pfx,
    input logic [IMM_W-1:0] field,
    input logic [1:0]       src
  );
    logic [XLEN-1:0]    pfx_wide;
    logic [UPPER_W-1:0] upper;
    logic [XLEN-1:0]    comb_val;
    logic               sign_mode;
    sign_mode = src[1];
    // Widen the prefix to XLEN first so UPPER_W smaller than IMM_W still works.
    if (sign_mode) begin
      pfx_wide = {{UPPER_W{pfx[IMM_W-1]}}, pfx};
    end else begin
      pfx_wide = {{UPPER_W{1'b0}}, pfx};
    end
    if (use_pfx) begin
      upper = pfx_wide[UPPER_W-1:0];
    end else if (sign_mode) begin
      upper = {UPPER_W{field[IMM_W-1]}};
    end else begin
      upper = {UPPER_W{1'b0}};
    end
    comb_val = {upper, field};
    case (src)
      2'b11:   comb_val = {comb_val[XLEN-3:0], 2'b00};
      default: comb_val = comb_val;
    endcase
    return comb_val;
  endfunction

  // Ready depends only on the output register state (pass-through backpressure).
  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= NO_PREFIX;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: flush wins, any prefix (re)loads, a consumer releases.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = NO_PREFIX;
    end else if (accept_s && bus.is_prefix) begin
      state_nxt_s = PREFIX_HELD;
    end else if (accept_s) begin
      state_nxt_s = NO_PREFIX;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs / datapath next values for the output and prefix registers.
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    ext_imm_nxt_s   = ext_imm_r;
    prefix_nxt_s    = prefix_r;
    if (bus.flush) begin
      // Beat presented alongside a flush is dropped; ext_imm is left as is.
      out_valid_nxt_s = 1'b0;
      prefix_nxt_s    = {IMM_W{1'b0}};
    end else if (accept_s && bus.is_prefix) begin
      // A prefix produces no output beat; the previous one has drained.
      out_valid_nxt_s = 1'b0;
      prefix_nxt_s    = bus.imm_field;
    end else if (accept_s) begin
      out_valid_nxt_s = 1'b1;
      ext_imm_nxt_s   = extend_imm(prefix_r, (state_r == PREFIX_HELD),
                                   bus.imm_field, bus.imm_src);
    end else if (bus.out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Output, prefix and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r      <= 1'b0;
      ext_imm_r        <= {XLEN{1'b0}};
      prefix_r         <= {IMM_W{1'b0}};
      prefix_pending_r <= 1'b0;
    end else begin
      out_valid_r      <= out_valid_nxt_s;
      ext_imm_r        <= ext_imm_nxt_s;
      prefix_r         <= prefix_nxt_s;
      prefix_pending_r <= (state_nxt_s == PREFIX_HELD);
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_r;
  assign bus.ext_imm        = ext_imm_r;
  assign bus.prefix_pending = prefix_pending_r;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_extend_pipe
// Directed self-checking bench for imm_extend_pipe (IMM_W=24, XLEN=64).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_imm_extend_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  imm_extend_pipe_if #(.IMM_W(24), .XLEN(64)) bus ();

  imm_extend_pipe #(.IMM_W(24), .XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic pfx, input logic [1:0] src, input logic [23:0] field);
    bus.in_valid  = v;
    bus.is_prefix = pfx;
    bus.imm_src   = src;
    bus.imm_field = field;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 24'h000000);

    // Reset state
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_ext_imm", bus.ext_imm, 64'd0);
    check("rst_pending", {63'd0, bus.prefix_pending}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Plain extension modes, back to back
    drive(1'b1, 1'b0, 2'b00, 24'hFFFFFF);
    @(negedge clk);
    check("m00_valid", {63'd0, bus.out_valid}, 64'd1);
    check("m00_imm", bus.ext_imm, 64'h0000_0000_00FF_FFFF);
    drive(1'b1, 1'b0, 2'b10, 24'h800001);
    @(negedge clk);
    check("m10_imm", bus.ext_imm, 64'hFFFF_FFFF_FF80_0001);
    drive(1'b1, 1'b0, 2'b11, 24'h800001);
    @(negedge clk);
    check("m11_imm", bus.ext_imm, 64'hFFFF_FFFF_FE00_0004);
    drive(1'b1, 1'b0, 2'b01, 24'h812345);
    @(negedge clk);
    check("m01_imm", bus.ext_imm, 64'h0000_0000_0081_2345);

    // Prefix while previous output drains, then consumer
    drive(1'b1, 1'b1, 2'b00, 24'h000123);
    @(negedge clk);
    check("pfx_valid_low", {63'd0, bus.out_valid}, 64'd0);
    check("pfx_pending", {63'd0, bus.prefix_pending}, 64'd1);
    drive(1'b1, 1'b0, 2'b00, 24'h456789);
    @(negedge clk);
    check("pfx_cons_valid", {63'd0, bus.out_valid}, 64'd1);
    check("pfx_cons_imm", bus.ext_imm, 64'h0000_0001_2345_6789);
    check("pfx_cons_pending", {63'd0, bus.prefix_pending}, 64'd0);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    @(negedge clk);
    check("idle_valid", {63'd0, bus.out_valid}, 64'd0);

    // Prefix sign-extended for modes 10/11, zero-extended for 01
    drive(1'b1, 1'b1, 2'b00, 24'h800000);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 24'h000001);
    @(negedge clk);
    check("pfx_m10_imm", bus.ext_imm, 64'hFFFF_8000_0000_0001);
    drive(1'b1, 1'b1, 2'b00, 24'h800000);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b11, 24'h000001);
    @(negedge clk);
    check("pfx_m11_imm", bus.ext_imm, 64'hFFFE_0000_0000_0004);
    drive(1'b1, 1'b1, 2'b00, 24'h800000);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 24'h000002);
    @(negedge clk);
    check("pfx_m01_imm", bus.ext_imm, 64'h0000_8000_0000_0002);

    // Last prefix wins
    drive(1'b1, 1'b1, 2'b00, 24'h111111);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 24'h000002);
    @(negedge clk);
    check("pfx2_pending", {63'd0, bus.prefix_pending}, 64'd1);
    drive(1'b1, 1'b0, 2'b00, 24'h000003);
    @(negedge clk);
    check("pfx_last_imm", bus.ext_imm, 64'h0000_0000_0200_0003);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    @(negedge clk);

    // Backpressure: first beat stalls, second beat waits upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 24'h0000AA);
    @(negedge clk);
    check("bp_first_imm", bus.ext_imm, 64'h0000_0000_0000_00AA);
    drive(1'b1, 1'b0, 2'b00, 24'h0000BB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_imm", bus.ext_imm, 64'h0000_0000_0000_00AA);
      check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    check("bp_second_imm", bus.ext_imm, 64'h0000_0000_0000_00BB);
    check("bp_second_valid", {63'd0, bus.out_valid}, 64'd1);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    @(negedge clk);
    check("bp_drained", {63'd0, bus.out_valid}, 64'd0);

    // Flush with prefix held and a concurrent beat
    drive(1'b1, 1'b1, 2'b00, 24'h000555);
    @(negedge clk);
    check("fl_pending_before", {63'd0, bus.prefix_pending}, 64'd1);
    bus.flush = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 24'h000077);
    @(negedge clk);
    check("fl_valid", {63'd0, bus.out_valid}, 64'd0);
    check("fl_pending", {63'd0, bus.prefix_pending}, 64'd0);
    bus.flush = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 24'h000010);
    @(negedge clk);
    check("fl_after_imm", bus.ext_imm, 64'h0000_0000_0000_0010);
    check("fl_after_valid", {63'd0, bus.out_valid}, 64'd1);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    @(negedge clk);

    // Async reset mid-stall with a valid output
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 24'h5A5A5A);
    @(negedge clk);
    check("ar_stall_valid", {63'd0, bus.out_valid}, 64'd1);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {63'd0, bus.out_valid}, 64'd0);
    check("ar_imm", bus.ext_imm, 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Async reset with a prefix held
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 24'h000123);
    @(negedge clk);
    check("ar_pfx_pending_set", {63'd0, bus.prefix_pending}, 64'd1);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pfx_pending", {63'd0, bus.prefix_pending}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 24'h000001);
    @(negedge clk);
    check("ar_no_pfx_imm", bus.ext_imm, 64'h0000_0000_0000_0001);
    drive(1'b0, 1'b0, 2'b00, 24'h000000);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
